// File: rtl/hazard_ctrl.sv
// Pipeline sequencing: load-use stalls, taken-branch flushes, dmem waits.
// Define HAZARD_PERF_EN to build the saturating performance counters.
module hazard_ctrl #(
   parameter int STALL_CYCLES = 1,
   parameter int WAIT_TIMEOUT = 255
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        IDEX_MemRead,
   input  logic [4:0]  IDEX_Rt,
   input  logic [4:0]  IFID_Rs,
   input  logic [4:0]  IFID_Rt,
   input  logic        IFID_UsesRt,
   input  logic        EXMEM_Branch,
   input  logic        EXMEM_Zero,
   input  logic        EXMEM_Jump,
   input  logic        EXMEM_MemRead,
   input  logic        EXMEM_MemWrite,
   input  logic        DMemReady,
   output logic        PCWrite,
   output logic        PCSel,
   output logic        IFIDWrite,
   output logic        FlushIFID,
   output logic        FlushIDEX,
   output logic        FlushEXMEM,
   output logic        PipeHold,
   output logic        MEMWBBubble,
   output logic        MemTimeout,
   output logic [15:0] StallCount,
   output logic [15:0] FlushCount,
   output logic [15:0] WaitCount
);

   typedef enum logic [1:0] {RUN, STALL, WAIT} state_t;
   typedef enum logic [1:0] {
      ACT_NONE, ACT_HOLD, ACT_FLUSH, ACT_STALL
   } act_t;

   localparam logic [1:0]  STALL_LOAD = 2'(STALL_CYCLES - 1);
   localparam logic [15:0] TIMEOUT    = 16'(WAIT_TIMEOUT);

   state_t      state, state_nx;
   act_t        act;
   logic [1:0]  stall_cnt, stall_cnt_nx;
   logic [15:0] wait_cnt, wait_cnt_nx;
   logic        timeout_q, timeout_set;
   logic        mem_busy, taken, load_use, rt_hit;

   assign mem_busy = (EXMEM_MemRead | EXMEM_MemWrite) & ~DMemReady;
   assign taken    = (EXMEM_Branch & EXMEM_Zero) | EXMEM_Jump;
   assign rt_hit   = IFID_UsesRt & (IDEX_Rt == IFID_Rt);
   assign load_use = IDEX_MemRead & (IDEX_Rt != 5'd0)
                   & ((IDEX_Rt == IFID_Rs) | rt_hit);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= RUN;
         stall_cnt <= 2'd0;
         wait_cnt  <= 16'd0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nx;
         stall_cnt <= stall_cnt_nx;
         wait_cnt  <= wait_cnt_nx;
         if (timeout_set)
            timeout_q <= 1'b1;
      end
   end

   always_comb begin
      state_nx     = state;
      stall_cnt_nx = stall_cnt;
      wait_cnt_nx  = wait_cnt;
      timeout_set  = 1'b0;
      act          = ACT_NONE;
      unique case (state)
         RUN: begin
            if (mem_busy) begin
               act         = ACT_HOLD;
               wait_cnt_nx = 16'd1;
               state_nx    = WAIT;
            end else if (taken) begin
               act = ACT_FLUSH;
            end else if (load_use) begin
               act = ACT_STALL;
               if (STALL_CYCLES > 1) begin
                  stall_cnt_nx = STALL_LOAD;
                  state_nx     = STALL;
               end
            end
         end
         STALL: begin
            if (mem_busy) begin
               act          = ACT_HOLD;
               stall_cnt_nx = 2'd0;
               wait_cnt_nx  = 16'd1;
               state_nx     = WAIT;
            end else if (taken) begin
               act          = ACT_FLUSH;
               stall_cnt_nx = 2'd0;
               state_nx     = RUN;
            end else begin
               act          = ACT_STALL;
               stall_cnt_nx = stall_cnt - 2'd1;
               if (stall_cnt <= 2'd1)
                  state_nx = RUN;
            end
         end
         WAIT: begin
            // Memory never answered: let the pipe go and flag it.
            if (mem_busy && wait_cnt >= TIMEOUT) begin
               timeout_set = 1'b1;
               wait_cnt_nx = 16'd0;
               state_nx    = RUN;
            end else if (mem_busy) begin
               act         = ACT_HOLD;
               wait_cnt_nx = wait_cnt + 16'd1;
            end else begin
               wait_cnt_nx = 16'd0;
               state_nx    = RUN;
            end
         end
         default: state_nx = RUN;
      endcase
   end

   always_comb begin
      PCWrite     = 1'b1;
      IFIDWrite   = 1'b1;
      PCSel       = 1'b0;
      FlushIFID   = 1'b0;
      FlushIDEX   = 1'b0;
      FlushEXMEM  = 1'b0;
      PipeHold    = 1'b0;
      MEMWBBubble = 1'b0;
      unique case (act)
         ACT_HOLD: begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            PipeHold    = 1'b1;
            MEMWBBubble = 1'b1;
         end
         ACT_FLUSH: begin
            PCSel      = 1'b1;
            FlushIFID  = 1'b1;
            FlushIDEX  = 1'b1;
            FlushEXMEM = 1'b1;
         end
         ACT_STALL: begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            FlushIDEX = 1'b1;
         end
         default: ;
      endcase
      if (Reset) begin
         PCWrite   = 1'b0;
         IFIDWrite = 1'b0;
         PCSel     = 1'b0;
         FlushIFID = 1'b0;
         FlushIDEX = 1'b0;
         FlushEXMEM  = 1'b0;
         PipeHold    = 1'b0;
         MEMWBBubble = 1'b0;
      end
   end

   assign MemTimeout = timeout_q;

`ifdef HAZARD_PERF_EN
   logic [15:0] stall_q, flush_q, wait_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         stall_q <= 16'd0;
         flush_q <= 16'd0;
         wait_q  <= 16'd0;
      end else begin
         if (act == ACT_STALL && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
         if (act == ACT_FLUSH && flush_q != 16'hFFFF)
            flush_q <= flush_q + 16'd1;
         if (act == ACT_HOLD && wait_q != 16'hFFFF)
            wait_q <= wait_q + 16'd1;
      end
   end

   assign StallCount = stall_q;
   assign FlushCount = flush_q;
   assign WaitCount  = wait_q;
`else
   assign StallCount = 16'd0;
   assign FlushCount = 16'd0;
   assign WaitCount  = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1-cycle stall / 3-cycle stall with
// short timeout) against a cycle-level behavioural model.
module tb_hazard_ctrl;

   localparam int SC_A = 1, TO_A = 255;
   localparam int SC_B = 3, TO_B = 8;

   typedef struct packed {
      logic       rst;
      logic       idex_mr;
      logic [4:0] idex_rt;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urt;
      logic       br;
      logic       z;
      logic       j;
      logic       emr;
      logic       emw;
      logic       rdy;
   } stim_t;

   logic  clk = 1'b0;
   stim_t s;
   int    checks = 0;
   int    passed = 0;

   wire [8:0]  ctl_a, ctl_b;
   wire [15:0] sca, fca, wca, scb, fcb, wcb;
   wire [56:0] obs [2];
   logic [56:0] exp_v [2];

   // model state per instance
   int stall_left [2];
   int held [2];
   bit tmo [2];
   int ns [2], nf [2], nw [2];

   assign obs[0] = {ctl_a, sca, fca, wca};
   assign obs[1] = {ctl_b, scb, fcb, wcb};

   always #5 clk = ~clk;

   hazard_ctrl #(.STALL_CYCLES(SC_A), .WAIT_TIMEOUT(TO_A)) u_a (
      .Clk(clk), .Reset(s.rst),
      .IDEX_MemRead(s.idex_mr), .IDEX_Rt(s.idex_rt),
      .IFID_Rs(s.rs), .IFID_Rt(s.rt), .IFID_UsesRt(s.urt),
      .EXMEM_Branch(s.br), .EXMEM_Zero(s.z), .EXMEM_Jump(s.j),
      .EXMEM_MemRead(s.emr), .EXMEM_MemWrite(s.emw),
      .DMemReady(s.rdy),
      .PCWrite(ctl_a[8]), .IFIDWrite(ctl_a[7]), .PCSel(ctl_a[6]),
      .FlushIFID(ctl_a[5]), .FlushIDEX(ctl_a[4]),
      .FlushEXMEM(ctl_a[3]), .PipeHold(ctl_a[2]),
      .MEMWBBubble(ctl_a[1]), .MemTimeout(ctl_a[0]),
      .StallCount(sca), .FlushCount(fca), .WaitCount(wca)
   );

   hazard_ctrl #(.STALL_CYCLES(SC_B), .WAIT_TIMEOUT(TO_B)) u_b (
      .Clk(clk), .Reset(s.rst),
      .IDEX_MemRead(s.idex_mr), .IDEX_Rt(s.idex_rt),
      .IFID_Rs(s.rs), .IFID_Rt(s.rt), .IFID_UsesRt(s.urt),
      .EXMEM_Branch(s.br), .EXMEM_Zero(s.z), .EXMEM_Jump(s.j),
      .EXMEM_MemRead(s.emr), .EXMEM_MemWrite(s.emw),
      .DMemReady(s.rdy),
      .PCWrite(ctl_b[8]), .IFIDWrite(ctl_b[7]), .PCSel(ctl_b[6]),
      .FlushIFID(ctl_b[5]), .FlushIDEX(ctl_b[4]),
      .FlushEXMEM(ctl_b[3]), .PipeHold(ctl_b[2]),
      .MEMWBBubble(ctl_b[1]), .MemTimeout(ctl_b[0]),
      .StallCount(scb), .FlushCount(fcb), .WaitCount(wcb)
   );

   // kind: 0 free-running, 1 memory hold, 2 redirect, 3 load-use bubble
   task automatic model(input int d, output logic [56:0] e);
      bit busy, tk, lu, t_prev;
      int kind, lim_s, lim_t;
      logic [8:0] c;
      lim_s = (d == 0) ? SC_A : SC_B;
      lim_t = (d == 0) ? TO_A : TO_B;
      busy = (s.emr || s.emw) && !s.rdy;
      tk = (s.br && s.z) || s.j;
      lu = s.idex_mr && s.idex_rt != 0 &&
           (s.idex_rt == s.rs || (s.urt && s.idex_rt == s.rt));
      if (s.rst) begin
         stall_left[d] = 0; held[d] = 0; tmo[d] = 0;
         ns[d] = 0; nf[d] = 0; nw[d] = 0;
         e = '0;
         return;
      end
      t_prev = tmo[d];
      kind = 0;
      if (held[d] > 0) begin
         if (busy && held[d] >= lim_t) begin
            tmo[d] = 1; held[d] = 0;
         end else if (busy) begin
            kind = 1; held[d]++;
         end else held[d] = 0;
      end else if (stall_left[d] > 0) begin
         if (busy) begin
            kind = 1; stall_left[d] = 0; held[d] = 1;
         end else if (tk) begin
            kind = 2; stall_left[d] = 0;
         end else begin
            kind = 3; stall_left[d]--;
         end
      end else if (busy) begin
         kind = 1; held[d] = 1;
      end else if (tk) kind = 2;
      else if (lu) begin
         kind = 3; stall_left[d] = lim_s - 1;
      end
      case (kind)
         1: c = {8'b0000_0011, t_prev};
         2: c = {8'b1111_1100, t_prev};
         3: c = {8'b0000_1000, t_prev};
         default: c = {8'b1100_0000, t_prev};
      endcase
`ifdef HAZARD_PERF_EN
      e = {c, 16'(ns[d]), 16'(nf[d]), 16'(nw[d])};
      if (kind == 3 && ns[d] < 65535) ns[d]++;
      if (kind == 2 && nf[d] < 65535) nf[d]++;
      if (kind == 1 && nw[d] < 65535) nw[d]++;
`else
      e = {c, 48'd0};
`endif
   endtask

   task automatic step(input stim_t t);
      @(posedge clk); #1;
      s = t;
      @(negedge clk);
      for (int d = 0; d < 2; d++) model(d, exp_v[d]);
   endtask

   function automatic stim_t hazard();
      stim_t t = '0;
      t.idex_mr = 1'b1; t.idex_rt = 5'd5; t.rs = 5'd5;
      return t;
   endfunction

   task automatic test_reset();
      stim_t t = '0;
      for (int c = 0; c < 3; c++) begin
         t.rst = (c < 2);
         step(t);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== exp_v[d])
               $display("FAIL reset dut%0d cyc%0d got %h want %h",
                        d, c, obs[d], exp_v[d]);
            else passed++;
         end
      end
   endtask

   task automatic test_load_use();
      int stalls_b = 0;
      for (int c = 0; c < 4; c++) begin
         step(c == 0 ? hazard() : stim_t'('0));
         stalls_b += int'(ctl_b[4]);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== exp_v[d])
               $display("FAIL load_use dut%0d cyc%0d got %h want %h",
                        d, c, obs[d], exp_v[d]);
            else passed++;
         end
         checks++;
         if (ctl_a[8:1] !== (c == 0 ? 8'b0000_1000 : 8'b1100_0000))
            $display("FAIL load_use_a cyc%0d got %b want stall-then-run",
                     c, ctl_a[8:1]);
         else passed++;
      end
      checks++;
      if (stalls_b !== 3)
         $display("FAIL stall3_len got %0d want 3", stalls_b);
      else passed++;
   endtask

   task automatic test_stall_taken();
      stim_t t;
      for (int c = 0; c < 4; c++) begin
         t = '0;
         if (c == 0) t = hazard();
         if (c == 1) t.j = 1'b1;
         step(t);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== exp_v[d])
               $display("FAIL stall_taken dut%0d cyc%0d got %h want %h",
                        d, c, obs[d], exp_v[d]);
            else passed++;
         end
         if (c == 1 || c == 2) begin
            checks++;
            if (ctl_b[8:1] !== (c == 1 ? 8'b1111_1100 : 8'b1100_0000))
               $display("FAIL stall_abort cyc%0d got %b", c, ctl_b[8:1]);
            else passed++;
         end
      end
   endtask

   task automatic test_taken_loaduse();
      stim_t t;
      for (int c = 0; c < 3; c++) begin
         t = (c == 0) ? hazard() : stim_t'('0);
         t.j = (c == 0);
         step(t);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== exp_v[d])
               $display("FAIL taken_lu dut%0d cyc%0d got %h want %h",
                        d, c, obs[d], exp_v[d]);
            else passed++;
         end
         checks++;
         if (ctl_b[8:1] !== (c == 0 ? 8'b1111_1100 : 8'b1100_0000))
            $display("FAIL taken_lu_b cyc%0d got %b", c, ctl_b[8:1]);
         else passed++;
      end
   endtask

   task automatic test_mem_wait();
      stim_t t;
      int holds_a = 0;
      for (int c = 0; c < 6; c++) begin
         t = '0;
         t.emr = (c < 5);
         t.rdy = (c == 4);
         step(t);
         holds_a += int'(ctl_a[2]);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== exp_v[d])
               $display("FAIL mem_wait dut%0d cyc%0d got %h want %h",
                        d, c, obs[d], exp_v[d]);
            else passed++;
         end
      end
      checks++;
      if (holds_a !== 4)
         $display("FAIL mem_wait_len got %0d want 4", holds_a);
      else passed++;
   endtask

   task automatic test_timeout();
      stim_t t;
      int run_b = 0;
      bit open = 1;
      for (int c = 0; c < 14; c++) begin
         t = '0;
         t.emw = (c < 12);
         step(t);
         if (open && ctl_b[2]) run_b++;
         else open = 0;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== exp_v[d])
               $display("FAIL timeout dut%0d cyc%0d got %h want %h",
                        d, c, obs[d], exp_v[d]);
            else passed++;
         end
      end
      checks++;
      if (run_b !== 8)
         $display("FAIL timeout_len got %0d want 8", run_b);
      else passed++;
      checks++;
      if (ctl_b[0] !== 1'b1 || ctl_a[0] !== 1'b0)
         $display("FAIL timeout_flag got b=%b a=%b want 1,0",
                  ctl_b[0], ctl_a[0]);
      else passed++;
   endtask

   task automatic test_reset_mid_wait();
      stim_t t;
      for (int c = 0; c < 6; c++) begin
         t = '0;
         t.emr = (c < 4);
         t.rst = (c == 2);
         t.rdy = (c == 3);
         step(t);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== exp_v[d])
               $display("FAIL rst_wait dut%0d cyc%0d got %h want %h",
                        d, c, obs[d], exp_v[d]);
            else passed++;
         end
         if (c == 2 || c == 4) begin
            checks++;
            if (ctl_b !== (c == 2 ? 9'd0 : 9'b1100_0000_0))
               $display("FAIL rst_wait_b cyc%0d got %b", c, ctl_b);
            else passed++;
         end
      end
   endtask

   task automatic test_random();
      stim_t t;
      for (int c = 0; c < 600; c++) begin
         t.rst     = ($urandom_range(0, 79) == 0);
         t.idex_mr = 1'($urandom_range(0, 1));
         t.idex_rt = 5'($urandom_range(0, 3));
         t.rs      = 5'($urandom_range(0, 3));
         t.rt      = 5'($urandom_range(0, 3));
         t.urt     = 1'($urandom_range(0, 1));
         t.br      = ($urandom_range(0, 3) == 0);
         t.z       = 1'($urandom_range(0, 1));
         t.j       = ($urandom_range(0, 9) == 0);
         t.emr     = ($urandom_range(0, 4) == 0);
         t.emw     = ($urandom_range(0, 6) == 0);
         t.rdy     = ($urandom_range(0, 3) == 0);
         step(t);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== exp_v[d])
               $display("FAIL random dut%0d cyc%0d got %h want %h",
                        d, c, obs[d], exp_v[d]);
            else passed++;
         end
      end
   endtask

   initial begin
      s = '0;
      s.rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         stall_left[d] = 0; held[d] = 0; tmo[d] = 0;
         ns[d] = 0; nf[d] = 0; nw[d] = 0;
      end
      test_reset();
      test_load_use();
      test_stall_taken();
      test_taken_loaduse();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
